// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default register-bank geometry, address type
// and the register-index names used by the control unit.
package datapath_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t R0 = reg_addr_t'(0);
  localparam reg_addr_t R1 = reg_addr_t'(1);
  localparam reg_addr_t R2 = reg_addr_t'(2);
  localparam reg_addr_t R3 = reg_addr_t'(3);
  localparam reg_addr_t R4 = reg_addr_t'(4);
  localparam reg_addr_t R5 = reg_addr_t'(5);
  localparam reg_addr_t R6 = reg_addr_t'(6);
  localparam reg_addr_t R7 = reg_addr_t'(7);

endpackage

// File: rtl/reg_bank_2r1w_if.sv
// Control-side bundle of the 2-read/1-write register bank: two read ports,
// one write port, reserve request and the pending count.
interface reg_bank_2r1w_if #(
  parameter int WIDTH = datapath_pkg::WIDTH_DEF,
  parameter int AW    = datapath_pkg::AW_DEF
);
  logic             rda_en;
  logic [AW-1:0]    rda_addr;
  logic [WIDTH-1:0] rda_data;
  logic             pend_a;
  logic             rdb_en;
  logic [AW-1:0]    rdb_addr;
  logic [WIDTH-1:0] rdb_data;
  logic             pend_b;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [AW:0]      pend_cnt;

  modport master (
    output rda_en, rda_addr, rdb_en, rdb_addr,
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rda_data, pend_a, rdb_data, pend_b, pend_cnt
  );

  modport slave (
    input  rda_en, rda_addr, rdb_en, rdb_addr,
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rda_data, pend_a, rdb_data, pend_b, pend_cnt
  );
endinterface

// File: rtl/reg_bank_2r1w_rdport.sv
// One registered read port: address decode, same-cycle write bypass and the
// data/pending output registers.
module reg_bank_rdport
  import datapath_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0] pend,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_pend
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  logic             rd_ok;
  logic             byp;
  logic [WIDTH-1:0] data_p0;
  logic             pend_p0;

  // Bypass only when the write itself would land, so R0/out-of-range writes never leak.
  always_comb begin
    rd_ok   = addr_ok(rd_addr);
    byp     = wr_en && (wr_addr == rd_addr) && rd_ok;
    data_p0 = '0;
    pend_p0 = 1'b0;
    if (byp) begin
      data_p0 = wr_data;
    end else if (rd_ok) begin
      data_p0 = mem[rd_addr];
      pend_p0 = pend[rd_addr];
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_pend <= 1'b0;
    end else if (rd_en) begin
      rd_data <= data_p0;
      rd_pend <= pend_p0;
    end
  end

endmodule

// File: rtl/reg_bank_2r1w.sv
// Register bank with two registered read ports, one write port with bypass,
// and per-register pending bits with an incrementally maintained count.
module reg_bank_2r1w
  import datapath_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ZERO_R0 = 0
) (
  input logic             clk,
  input logic             rst,
  reg_bank_2r1w_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             rsv_ok;
  logic             inc;
  logic             dec;

  // A write+reserve to one address leaves the bit set, so that write never decrements.
  always_comb begin
    wr_ok    = bus.wr_en && addr_ok(bus.wr_addr);
    rsv_ok   = bus.rsv_en && addr_ok(bus.rsv_addr);
    inc      = rsv_ok && !pend[bus.rsv_addr];
    dec      = wr_ok && pend[bus.wr_addr] && !(rsv_ok && (bus.rsv_addr == bus.wr_addr));
    pend_nxt = pend;
    if (wr_ok)  pend_nxt[bus.wr_addr]  = 1'b0;
    if (rsv_ok) pend_nxt[bus.rsv_addr] = 1'b1;
    cnt_nxt = cnt;
    if (inc && !dec)      cnt_nxt = cnt + 1'b1;
    else if (dec && !inc) cnt_nxt = cnt - 1'b1;
  end

  // Storage / scoreboard update stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.pend_cnt = cnt;

  reg_bank_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rda (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (bus.rda_en),
    .rd_addr (bus.rda_addr),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .mem     (mem),
    .pend    (pend),
    .rd_data (bus.rda_data),
    .rd_pend (bus.pend_a)
  );

  reg_bank_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rdb (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (bus.rdb_en),
    .rd_addr (bus.rdb_addr),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .mem     (mem),
    .pend    (pend),
    .rd_data (bus.rdb_data),
    .rd_pend (bus.pend_b)
  );

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Bench for reg_bank_2r1w: drives one stimulus into a normal and a ZERO_R0
// instance, checks both against an array model every cycle plus literal checks.
module tb_reg_bank_2r1w;
  import datapath_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rda_en, rdb_en, wr_en, rsv_en;
  logic [2:0]  rda_addr, rdb_addr, wr_addr, rsv_addr;
  logic [15:0] wr_data;

  reg_bank_2r1w_if #(.WIDTH(16), .AW(3)) if0 ();
  reg_bank_2r1w_if #(.WIDTH(16), .AW(3)) if1 ();

  assign if0.rda_en = rda_en;  assign if1.rda_en = rda_en;
  assign if0.rda_addr = rda_addr;  assign if1.rda_addr = rda_addr;
  assign if0.rdb_en = rdb_en;  assign if1.rdb_en = rdb_en;
  assign if0.rdb_addr = rdb_addr;  assign if1.rdb_addr = rdb_addr;
  assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
  assign if0.rsv_en = rsv_en;  assign if1.rsv_en = rsv_en;
  assign if0.rsv_addr = rsv_addr;  assign if1.rsv_addr = rsv_addr;

  reg_bank_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_bank_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int nvec = 0;
  int nbad = 0;
  bit cmp_on = 1'b0;

  // Model: k=0 normal bank, k=1 bank with R0 hardwired to zero
  logic [15:0] m_mem  [2][8];
  bit          m_pend [2][8];
  logic [15:0] e_rda [2], e_rdb [2];
  bit          e_pa [2], e_pb [2];

  function automatic bit m_valid(int k, logic [2:0] a);
    return !(k == 1 && a == 3'd0);
  endfunction

  function automatic int m_count(int k);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_pend[k][i]);
    return n;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin m_mem[k][i] = '0; m_pend[k][i] = 1'b0; end
      e_rda[k] = '0; e_rdb[k] = '0; e_pa[k] = 1'b0; e_pb[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin m_mem[k][i] = '0; m_pend[k][i] = 1'b0; end
        e_rda[k] = '0; e_rdb[k] = '0; e_pa[k] = 1'b0; e_pb[k] = 1'b0;
      end else begin
        if (rda_en) begin
          if (!m_valid(k, rda_addr)) begin e_rda[k] = '0; e_pa[k] = 1'b0; end
          else if (wr_en && wr_addr == rda_addr) begin e_rda[k] = wr_data; e_pa[k] = 1'b0; end
          else begin e_rda[k] = m_mem[k][rda_addr]; e_pa[k] = m_pend[k][rda_addr]; end
        end
        if (rdb_en) begin
          if (!m_valid(k, rdb_addr)) begin e_rdb[k] = '0; e_pb[k] = 1'b0; end
          else if (wr_en && wr_addr == rdb_addr) begin e_rdb[k] = wr_data; e_pb[k] = 1'b0; end
          else begin e_rdb[k] = m_mem[k][rdb_addr]; e_pb[k] = m_pend[k][rdb_addr]; end
        end
        if (wr_en && m_valid(k, wr_addr)) begin
          m_mem[k][wr_addr]  = wr_data;
          m_pend[k][wr_addr] = 1'b0;
        end
        if (rsv_en && m_valid(k, rsv_addr)) m_pend[k][rsv_addr] = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp("m0.rda_data", int'(if0.rda_data), int'(e_rda[0]));
      cmp("m0.pend_a",   int'(if0.pend_a),   int'(e_pa[0]));
      cmp("m0.rdb_data", int'(if0.rdb_data), int'(e_rdb[0]));
      cmp("m0.pend_b",   int'(if0.pend_b),   int'(e_pb[0]));
      cmp("m0.pend_cnt", int'(if0.pend_cnt), m_count(0));
      cmp("m1.rda_data", int'(if1.rda_data), int'(e_rda[1]));
      cmp("m1.pend_a",   int'(if1.pend_a),   int'(e_pa[1]));
      cmp("m1.rdb_data", int'(if1.rdb_data), int'(e_rdb[1]));
      cmp("m1.pend_b",   int'(if1.pend_b),   int'(e_pb[1]));
      cmp("m1.pend_cnt", int'(if1.pend_cnt), m_count(1));
    end
  end

  task automatic idle();
    rst = 1'b0; rda_en = 1'b0; rdb_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    rda_addr = '0; rdb_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rsv(input logic [2:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic rda(input logic [2:0] a);
    rda_en = 1'b1; rda_addr = a;
  endtask

  task automatic rdb(input logic [2:0] a);
    rdb_en = 1'b1; rdb_addr = a;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick();
    cmp_on = 1'b1;

    // Reset clears a written register
    wr(R1, 16'h0404); tick();
    rst = 1'b1; tick();
    rda(R1); tick();
    cmp("rst.rda_data", int'(if0.rda_data), 16'h0000);
    cmp("rst.pend_a",   int'(if0.pend_a), 0);
    cmp("rst.pend_cnt", int'(if0.pend_cnt), 0);

    // Dual read, then hold with enables low
    wr(R1, 16'h0404); tick();
    wr(R2, 16'h0407); tick();
    rda(R1); rdb(R2); tick();
    cmp("dual.rda_data", int'(if0.rda_data), 16'h0404);
    cmp("dual.rdb_data", int'(if0.rdb_data), 16'h0407);
    tick(); tick();
    cmp("hold.rda_data", int'(if0.rda_data), 16'h0404);
    cmp("hold.rdb_data", int'(if0.rdb_data), 16'h0407);

    // Bypass on both ports over an older value
    wr(R3, 16'h5555); tick();
    wr(R3, 16'h00AA); rda(R3); rdb(R3); tick();
    cmp("byp.rda_data", int'(if0.rda_data), 16'h00AA);
    cmp("byp.rdb_data", int'(if0.rdb_data), 16'h00AA);

    // Scoreboard
    rsv(R4); tick();
    cmp("sb.cnt_rsv", int'(if0.pend_cnt), 1);
    rda(R4); tick();
    cmp("sb.pend_a_set", int'(if0.pend_a), 1);
    wr(R4, 16'h000C); tick();
    cmp("sb.cnt_clr", int'(if0.pend_cnt), 0);
    rda(R4); tick();
    cmp("sb.rda_after", int'(if0.rda_data), 16'h000C);
    cmp("sb.pend_after", int'(if0.pend_a), 0);
    wr(R5, 16'h0055); rsv(R5); tick();
    cmp("sb.wr_rsv_cnt", int'(if0.pend_cnt), 1);
    rda(R5); tick();
    cmp("sb.wr_rsv_data", int'(if0.rda_data), 16'h0055);
    cmp("sb.wr_rsv_pend", int'(if0.pend_a), 1);
    rsv(R6); rda(R6); tick();
    cmp("sb.rsv_rd_same", int'(if0.pend_a), 0);
    cmp("sb.cnt_two", int'(if0.pend_cnt), 2);
    rsv(R6); tick();
    cmp("sb.rsv_again", int'(if0.pend_cnt), 2);

    // R0 handling: hardwired in dut1, ordinary in dut0
    rst = 1'b1; tick();
    wr(R0, 16'hFFFF); rsv(R0); rda(R0); rdb(R0); tick();
    cmp("z1.byp_data", int'(if1.rda_data), 0);
    cmp("z0.byp_data", int'(if0.rda_data), 16'hFFFF);
    rda(R0); tick();
    cmp("z1.rda_data", int'(if1.rda_data), 0);
    cmp("z1.pend_a",   int'(if1.pend_a), 0);
    cmp("z1.pend_cnt", int'(if1.pend_cnt), 0);
    cmp("z0.pend_a",   int'(if0.pend_a), 1);
    cmp("z0.pend_cnt", int'(if0.pend_cnt), 1);

    // Reset mid-reservation with a simultaneous write
    rst = 1'b1; tick();
    rsv(R1); tick();
    rsv(R2); tick();
    rsv(R6); tick();
    cmp("mid.cnt3", int'(if0.pend_cnt), 3);
    wr(R1, 16'h1111); rsv(R3); tick();
    cmp("mid.cnt_net0", int'(if0.pend_cnt), 3);
    rst = 1'b1; wr(R1, 16'h1234); tick();
    rda(R1); tick();
    cmp("mid.rda_data", int'(if0.rda_data), 0);
    cmp("mid.pend_cnt", int'(if0.pend_cnt), 0);
    tick();

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
